// File: rtl/wb_uart_tx_device.sv
// Pipelined Wishbone write-only device: buffers data words in a small FIFO and
// serialises each one as an 8N1-style UART frame (start, LSB-first data, stop).
module wb_uart_tx_device #(
    parameter int DAT_WIDTH    = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cyc_i,
    input  logic                 stb_i,
    input  logic                 we_i,
    input  logic [DAT_WIDTH-1:0] dat_i,
    output logic                 ack_o,
    output logic                 err_o,
    output logic                 rty_o,
    output logic                 stall_o,
    output logic                 tx_o,
    output logic                 busy_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DAT_WIDTH + 1);
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_BIT   = IDX_W'(DAT_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } stateType;

    stateType             r_state;
    logic [TMR_W-1:0]     r_timer;
    logic [IDX_W-1:0]     r_bitIdx;
    logic [DAT_WIDTH-1:0] r_shiftReg;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_ack;
    logic                 r_err;

    logic [DAT_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wrPtr;
    logic [PTR_W-1:0]     r_rdPtr;
    logic [CNT_W-1:0]     r_count;

    logic w_full;
    logic w_acc;
    logic w_push;
    logic w_pop;

    // Stall looks only at the registered count, so a pop in the same cycle
    // does not free a slot until the following cycle.
    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_acc   = cyc_i & stb_i & ~w_full;
    assign w_push  = w_acc & we_i;
    assign w_pop   = (r_state == S_IDLE) & (r_count != '0);

    assign stall_o = w_full;
    assign ack_o   = r_ack & cyc_i;
    assign err_o   = r_err & cyc_i;
    assign rty_o   = 1'b0;
    assign tx_o    = r_tx;
    assign busy_o  = r_busy;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ack <= w_acc & we_i;
            r_err <= w_acc & ~we_i;
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // tx_o is registered from the current state, so the line lags the FSM by
    // one cycle uniformly and every bit still lasts CLKS_PER_BIT cycles.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_bitIdx   <= '0;
            r_shiftReg <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_busy <= (r_state != S_IDLE) | (r_count != '0);
            unique case (r_state)
                S_START: r_tx <= 1'b0;
                S_DATA:  r_tx <= r_shiftReg[0];
                default: r_tx <= 1'b1;
            endcase

            unique case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shiftReg <= r_mem[r_rdPtr];
                        r_timer    <= TMR_RELOAD;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    if (r_timer == '0) begin
                        r_timer  <= TMR_RELOAD;
                        r_bitIdx <= '0;
                        r_state  <= S_DATA;
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end
                S_DATA: begin
                    if (r_timer == '0) begin
                        r_timer    <= TMR_RELOAD;
                        r_shiftReg <= r_shiftReg >> 1;
                        if (r_bitIdx == LAST_BIT) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bitIdx <= r_bitIdx + IDX_W'(1);
                        end
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end
                S_STOP: begin
                    if (r_timer == '0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer - TMR_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_uart_tx_device.sv
// Directed bench for wb_uart_tx_device (CLKS_PER_BIT=4, FIFO_DEPTH=4, 8 data bits);
// a negedge UART receiver decodes tx_o so frame contents and spacing are checked.
module tb_wb_uart_tx_device;

    logic       clk_i;
    logic       rst_i;
    logic       cyc_i;
    logic       stb_i;
    logic       we_i;
    logic [7:0] dat_i;
    logic       ack_o;
    logic       err_o;
    logic       rty_o;
    logic       stall_o;
    logic       tx_o;
    logic       busy_o;

    int checks   = 0;
    int failures = 0;
    int frameErr = 0;

    logic [7:0] rxQ[$];
    logic [7:0] expQ[$];
    int         startQ[$];

    wb_uart_tx_device #(
        .DAT_WIDTH   (8),
        .FIFO_DEPTH  (4),
        .CLKS_PER_BIT(4)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .cyc_i  (cyc_i),
        .stb_i  (stb_i),
        .we_i   (we_i),
        .dat_i  (dat_i),
        .ack_o  (ack_o),
        .err_o  (err_o),
        .rty_o  (rty_o),
        .stall_o(stall_o),
        .tx_o   (tx_o),
        .busy_o (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic cyc, input logic stb, input logic we, input logic [7:0] dat);
        cyc_i = cyc;
        stb_i = stb;
        we_i  = we;
        dat_i = dat;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic frameBit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return d[idx-1];
    endfunction

    task automatic waitIdle(input string tag, input int budget);
        step;
        step;
        for (int i = 0; i < budget && busy_o !== 1'b0; i++) step;
        checkOutput(tag, busy_o, 0);
    endtask

    task automatic checkFrames(input string tag);
        checkOutput({tag, "_frames"}, rxQ.size(), expQ.size());
        for (int i = 0; i < rxQ.size() && i < expQ.size(); i++)
            checkOutput($sformatf("%s_byte%0d", tag, i), rxQ[i], expQ[i]);
        rxQ.delete();
        expQ.delete();
        startQ.delete();
    endtask

    // Receiver: samples the middle of every bit, aborts on reset.
    initial begin : monitor
        int phase;
        int monCycle;
        logic [7:0] sh;
        phase    = -1;
        monCycle = 0;
        sh       = '0;
        forever begin
            @(negedge clk_i);
            monCycle++;
            if (rst_i !== 1'b1) begin
                phase = -1;
            end else if (phase < 0) begin
                if (tx_o === 1'b0) begin
                    phase = 0;
                    startQ.push_back(monCycle);
                end
            end else begin
                phase++;
                if (phase >= 6 && phase <= 34 && ((phase - 6) % 4) == 0) begin
                    sh[(phase-6)/4] = tx_o;
                end else if (phase == 38) begin
                    if (tx_o !== 1'b1) frameErr++;
                    rxQ.push_back(sh);
                    phase = -1;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin : stimulus
        logic [7:0] d5[6];
        int  idx;
        int  ackCnt;
        int  stallSeen;
        int  lowCnt;
        logic accepted;

        rst_i = 1'b0;
        applyStimulus(0, 0, 0, 8'h00);

        // 1: reset
        repeat (3) step;
        checkOutput("rst_tx", tx_o, 1);
        checkOutput("rst_stall", stall_o, 0);
        checkOutput("rst_ack", ack_o, 0);
        checkOutput("rst_err", err_o, 0);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_rty", rty_o, 0);
        rst_i = 1'b1;
        step;

        // 2: single write 0xA5, tx low from the third sample after accept
        applyStimulus(1, 1, 1, 8'hA5);
        step;
        checkOutput("t2_ack", ack_o, 1);
        checkOutput("t2_tx_e0", tx_o, 1);
        applyStimulus(0, 0, 0, 8'h00);
        step;
        checkOutput("t2_ack_single", ack_o, 0);
        checkOutput("t2_busy", busy_o, 1);
        checkOutput("t2_tx_e1", tx_o, 1);
        for (int k = 0; k < 40; k++) begin
            step;
            checkOutput($sformatf("t2_tx_k%0d", k), tx_o, frameBit(8'hA5, k / 4));
        end
        checkOutput("t2_busy_stop", busy_o, 1);
        step;
        checkOutput("t2_busy_fall", busy_o, 0);
        checkOutput("t2_tx_idle", tx_o, 1);
        expQ.push_back(8'hA5);
        checkFrames("t2");

        // 3: six back-to-back writes with back-pressure
        idx = 0;
        ackCnt = 0;
        stallSeen = 0;
        applyStimulus(1, 1, 1, 8'h01);
        for (int c = 0; c < 200 && ackCnt < 6; c++) begin
            accepted = !stall_o;
            step;
            if (ack_o === 1'b1) ackCnt++;
            if (stall_o === 1'b1) stallSeen = 1;
            if (accepted) begin
                idx++;
                if (idx < 6) applyStimulus(1, 1, 1, 8'(idx + 1));
                else applyStimulus(0, 0, 0, 8'h00);
            end
        end
        applyStimulus(0, 0, 0, 8'h00);
        checkOutput("t3_acks", ackCnt, 6);
        checkOutput("t3_stall_seen", stallSeen, 1);
        waitIdle("t3_idle", 600);
        checkOutput("t3_starts", startQ.size(), 6);
        for (int i = 1; i < startQ.size(); i++)
            checkOutput($sformatf("t3_gap%0d", i), startQ[i] - startQ[i-1], 41);
        for (int i = 1; i <= 6; i++) expQ.push_back(8'(i));
        checkFrames("t3");

        // 4: read gives err only; write with cyc dropped in response cycle is still sent
        applyStimulus(1, 1, 0, 8'h55);
        step;
        checkOutput("t4_err", err_o, 1);
        checkOutput("t4_no_ack", ack_o, 0);
        applyStimulus(0, 0, 0, 8'h00);
        step;
        checkOutput("t4_err_single", err_o, 0);
        checkOutput("t4_no_push_busy", busy_o, 0);
        checkOutput("t4_stall", stall_o, 0);
        applyStimulus(1, 1, 1, 8'h3C);
        step;
        applyStimulus(0, 0, 0, 8'h00);
        #1;
        checkOutput("t4_ack_suppressed", ack_o, 0);
        expQ.push_back(8'h3C);
        waitIdle("t4_idle", 100);
        checkFrames("t4");

        // 5: write held while full; pop cycle still stalls; accepted one cycle later
        d5 = '{8'hFF, 8'h00, 8'h80, 8'h01, 8'h7E, 8'hC3};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, 1, d5[i]);
            step;
            checkOutput($sformatf("t5_ack%0d", i), ack_o, 1);
        end
        checkOutput("t5_stall_full", stall_o, 1);
        applyStimulus(1, 1, 1, d5[5]);
        lowCnt = 0;
        repeat (37) begin
            step;
            if (stall_o !== 1'b1) lowCnt++;
        end
        checkOutput("t5_stall_held", lowCnt, 0);
        checkOutput("t5_stall_pop_cycle", stall_o, 1);
        step;
        checkOutput("t5_no_accept_at_pop", ack_o, 0);
        checkOutput("t5_stall_after_pop", stall_o, 0);
        step;
        checkOutput("t5_ack_after_pop", ack_o, 1);
        applyStimulus(0, 0, 0, 8'h00);
        step;
        checkOutput("t5_ack_once", ack_o, 0);
        waitIdle("t5_idle", 400);
        for (int i = 0; i < 6; i++) expQ.push_back(d5[i]);
        checkFrames("t5");

        // 6: reset during data bit 3 of 0x55 with two words queued
        applyStimulus(1, 1, 1, 8'h55);
        step;
        applyStimulus(1, 1, 1, 8'hBB);
        step;
        applyStimulus(1, 1, 1, 8'hCC);
        step;
        applyStimulus(0, 0, 0, 8'h00);
        repeat (16) step;
        checkOutput("t6_tx_bit3", tx_o, 0);
        checkOutput("t6_busy_pre", busy_o, 1);
        rst_i = 1'b0;
        step;
        checkOutput("t6_tx_reset", tx_o, 1);
        checkOutput("t6_busy_reset", busy_o, 0);
        checkOutput("t6_stall_reset", stall_o, 0);
        checkOutput("t6_ack_reset", ack_o, 0);
        step;
        rst_i = 1'b1;
        lowCnt = 0;
        repeat (60) begin
            step;
            if (tx_o !== 1'b1 || busy_o !== 1'b0) lowCnt++;
        end
        checkOutput("t6_quiet_after_reset", lowCnt, 0);
        checkOutput("t6_frames", rxQ.size(), 0);
        checkOutput("stop_bit_errors", frameErr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
